// File: rtl/pc.sv
// pc -- fetch-stage program counter.
//
// Holds the address of the instruction being fetched. Every clock the PC
// advances by STEP unless it is held (stall), redirected to an absolute
// target (jump) or moved by a two's-complement offset (branch). All sums
// wrap modulo 2^WIDTH; there is no overflow indication.
//
// Next-state priority, highest first:
//   reset > [halt] > stall > jump > branch > +STEP
//
// Optional feature (macro PC_HALT_EN):
//   Adds i_halt/o_halted. A halt request sets a sticky halted flag and
//   freezes the PC on that edge and all later ones. Only reset clears it.
//
// Ports:
//   i_clk          system clock, rising-edge active
//   i_rst          synchronous reset, active-low (0 = reset)
//   i_stall        1 = hold PC this cycle
//   i_jump_en      1 = load i_jump_addr
//   i_jump_addr    absolute jump target
//   i_branch_en    1 = PC + i_branch_off
//   i_branch_off   two's-complement branch offset
//   i_halt         (PC_HALT_EN only) request sticky halt
//   o_halted       (PC_HALT_EN only) sticky halted flag
//   o_pc           current PC (registered)
//   o_pc_next      PC after the next edge, assuming i_rst=1 (combinational)
//   o_pc_plus_step o_pc + STEP (combinational, link-register value)

module pc #(
    parameter int unsigned       WIDTH       = 36,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter logic [WIDTH-1:0]  STEP        = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_jump_en,
    input  logic [WIDTH-1:0] i_jump_addr,
    input  logic             i_branch_en,
    input  logic [WIDTH-1:0] i_branch_off,
`ifdef PC_HALT_EN
    input  logic             i_halt,
    output logic             o_halted,
`endif
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_next,
    output logic [WIDTH-1:0] o_pc_plus_step
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus_step;
    logic [WIDTH-1:0] w_pc_branch;
    logic             w_freeze;

    // Unsigned addition of the two's-complement offset gives the signed
    // result modulo 2^WIDTH, so negative offsets wrap naturally.
    assign w_pc_plus_step = r_pc + STEP;
    assign w_pc_branch    = r_pc + i_branch_off;

`ifdef PC_HALT_EN
    logic r_halted;

    // The halting edge itself must not advance the PC, hence i_halt is
    // folded in alongside the registered flag.
    assign w_freeze = r_halted | i_halt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_halted <= 1'b0;
        end else if (i_halt) begin
            r_halted <= 1'b1;
        end
    end

    assign o_halted = r_halted;
`else
    assign w_freeze = 1'b0;
`endif

    always_comb begin
        w_pc_next = w_pc_plus_step;
        if (w_freeze || i_stall) begin
            w_pc_next = r_pc;
        end else if (i_jump_en) begin
            w_pc_next = i_jump_addr;
        end else if (i_branch_en) begin
            w_pc_next = w_pc_branch;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pc <= RESET_VALUE;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc           = r_pc;
    assign o_pc_next      = w_pc_next;
    assign o_pc_plus_step = w_pc_plus_step;

endmodule

// File: tb/tb_pc.sv
// tb_pc -- self-checking bench for pc (default parameters).
// Directed sequences with literal expectations, then randomized stimulus
// compared every cycle against a behavioural model built on 64-bit
// arithmetic reduced modulo 2^36.

module tb_pc;

    localparam int unsigned W = 36;
    localparam longint unsigned MOD = 64'h10_0000_0000;
    localparam longint unsigned STEP_M = 1;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         jump_en;
    logic [W-1:0] jump_addr;
    logic         branch_en;
    logic [W-1:0] branch_off;
    logic [W-1:0] pc_q;
    logic [W-1:0] pc_next;
    logic [W-1:0] pc_plus;
`ifdef PC_HALT_EN
    logic         halt;
    logic         halted;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    longint unsigned m_pc;
    logic            m_halted;
    logic            m_valid;

    pc dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_jump_en      (jump_en),
        .i_jump_addr    (jump_addr),
        .i_branch_en    (branch_en),
        .i_branch_off   (branch_off),
`ifdef PC_HALT_EN
        .i_halt         (halt),
        .o_halted       (halted),
`endif
        .o_pc           (pc_q),
        .o_pc_next      (pc_next),
        .o_pc_plus_step (pc_plus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // PC after the next edge if reset is not asserted.
    function automatic longint unsigned model_next(input longint unsigned pcv, input logic hltd);
        logic h;
        h = hltd;
`ifdef PC_HALT_EN
        h = h | halt;
`endif
        if (h || stall)   return pcv;
        if (jump_en)      return longint'(jump_addr);
        if (branch_en)    return (pcv + longint'(branch_off)) % MOD;
        return (pcv + STEP_M) % MOD;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_pc     <= 0;
            m_halted <= 1'b0;
            m_valid  <= 1'b1;
        end else if (m_valid) begin
            m_pc <= model_next(m_pc, m_halted);
`ifdef PC_HALT_EN
            if (halt) m_halted <= 1'b1;
`endif
        end
    end

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            check("cmp_pc", pc_q, W'(m_pc));
            check("cmp_plus_step", pc_plus, W'((m_pc + STEP_M) % MOD));
            check("cmp_pc_next", pc_next, W'(model_next(m_pc, m_halted)));
`ifdef PC_HALT_EN
            check("cmp_halted", W'(halted), W'(m_halted));
`endif
        end
    end

    task automatic drive(input logic r, input logic s, input logic je, input logic [W-1:0] ja,
                         input logic be, input logic [W-1:0] bo);
        rst = r; stall = s; jump_en = je; jump_addr = ja; branch_en = be; branch_off = bo;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_valid = 1'b0;
`ifdef PC_HALT_EN
        halt = 1'b0;
`endif
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #2;
        step();
        check("reset_pc", pc_q, 36'd0);
        check("reset_plus_step", pc_plus, 36'd1);

        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(); check("count_1", pc_q, 36'd1);
        step(); check("count_2", pc_q, 36'd2);
        step(); check("count_3", pc_q, 36'd3);
        check("count_plus_step", pc_plus, 36'd4);

        drive(1'b1, 1'b0, 1'b1, 36'd5, 1'b0, '0);
        step(); check("jump_5", pc_q, 36'd5);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        step(); check("stall_a", pc_q, 36'd5);
        step(); check("stall_b", pc_q, 36'd5);
        drive(1'b1, 1'b1, 1'b1, 36'd100, 1'b0, '0);
        #1 check("stall_mask_next", pc_next, 36'd5);
        step(); check("stall_masks_jump", pc_q, 36'd5);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(); check("stall_release", pc_q, 36'd6);

        drive(1'b1, 1'b0, 1'b1, 36'h0_0000_1000, 1'b1, 36'd8);
        step(); check("jump_over_branch", pc_q, 36'h1000);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(); check("after_jump", pc_q, 36'h1001);

        drive(1'b1, 1'b0, 1'b1, 36'd10, 1'b0, '0);
        step();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 36'hF_FFFF_FFFC);
        #1 check("branch_neg_next", pc_next, 36'd6);
        step(); check("branch_neg", pc_q, 36'd6);
        drive(1'b1, 1'b0, 1'b1, 36'd2, 1'b0, '0);
        step();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 36'hF_FFFF_FFFC);
        step(); check("branch_wrap", pc_q, 36'hF_FFFF_FFFE);

        drive(1'b1, 1'b0, 1'b1, 36'hF_FFFF_FFFF, 1'b0, '0);
        step(); check("jump_max", pc_q, 36'hF_FFFF_FFFF);
        check("plus_step_wrap", pc_plus, 36'd0);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(); check("step_wrap", pc_q, 36'd0);
        drive(1'b1, 1'b0, 1'b1, 36'd7, 1'b0, '0);
        step(); check("jump_7", pc_q, 36'd7);
        drive(1'b0, 1'b0, 1'b1, 36'd7, 1'b0, '0);
        step(); check("reset_over_jump", pc_q, 36'd0);

`ifdef PC_HALT_EN
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(); step(); step();
        check("halt_pre", pc_q, 36'd3);
        halt = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 36'd50, 1'b0, '0);
        step(); check("halt_pc", pc_q, 36'd3);
        check("halt_flag", W'(halted), 36'd1);
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); check("halt_frozen", pc_q, 36'd3);
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        step(); check("halt_reset_pc", pc_q, 36'd0);
        check("halt_reset_flag", W'(halted), 36'd0);
`endif

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] ja;
            logic [W-1:0] bo;
            int sel;
            sel = int'($urandom_range(0, 7));
            ja = {$urandom_range(0, 15), $urandom()};
            bo = {$urandom_range(0, 15), $urandom()};
            if (sel == 0) ja = 36'hF_FFFF_FFFF - W'($urandom_range(0, 3));
            if (sel == 1) bo = 36'hF_FFFF_FFFF - W'($urandom_range(0, 15));
            if (sel == 2) bo = W'($urandom_range(0, 15));
            drive($urandom_range(0, 31) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  ja,
                  $urandom_range(0, 2) == 0,
                  bo);
`ifdef PC_HALT_EN
            halt = ($urandom_range(0, 63) == 0);
`endif
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc.md
Name: pc

Overview:
- Program counter for the processor fetch stage; holds the 36-bit address of the instruction being fetched.
- Advances by a fixed step every clock, and can be held (stall), redirected to an absolute target (jump) or moved by a signed offset (branch).
- Its output drives the instruction-memory address and the fetch/decode pipeline register.

Parameters:
- WIDTH, 36, PC width in bits.
- RESET_VALUE, 36'd0, value loaded on reset.
- STEP, 1, increment applied per sequential cycle (unsigned, < 2^WIDTH).

Ports:
- i_clk  input  1  system clock, all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-low: sampled on rising i_clk, 0 = reset.
- i_stall  input  1  1 = hold PC for this cycle.
- i_jump_en  input  1  1 = load i_jump_addr.
- i_jump_addr  input  WIDTH  absolute jump target.
- i_branch_en  input  1  1 = PC <= PC + i_branch_off.
- i_branch_off  input  WIDTH  two's-complement branch offset.
- o_pc  output  WIDTH  current PC (registered).
- o_pc_next  output  WIDTH  value o_pc takes at next edge if i_rst=1 (combinational).
- o_pc_plus_step  output  WIDTH  o_pc + STEP (combinational, for link register).

Behaviour:
- Single clock domain. Reset is synchronous, active-low: i_rst=0 at a rising edge -> o_pc = RESET_VALUE after that edge. No asynchronous path.
- While reset is held low, o_pc stays RESET_VALUE. The first update happens at the first rising edge with i_rst=1.
- Next-state priority, highest first:
  - reset;
  - i_stall (o_pc unchanged);
  - i_jump_en (o_pc <= i_jump_addr);
  - i_branch_en (o_pc <= o_pc + i_branch_off);
  - default (o_pc <= o_pc + STEP).
- Simultaneous requests: stall masks jump and branch. Jump wins over branch. A masked request is dropped, not queued.
- Arithmetic: all sums are modulo 2^WIDTH.
  - 2^WIDTH-1 + 1 wraps to 0.
  - A negative branch offset below 0 wraps around.
  - No overflow flag.
- Latency: one cycle from any control input to o_pc. o_pc_next reflects the current inputs combinationally and equals the o_pc value after the next edge.
- o_pc_plus_step always equals o_pc + STEP mod 2^WIDTH, independent of control inputs.
- A reset asserted mid-stall, mid-jump or mid-branch takes precedence on that same edge.
- o_pc is a plain register. No X may propagate after the first reset edge.

Optional Feature:
- Macro: PC_HALT_EN.
- Defined:
  - Adds input i_halt (1 bit) and output o_halted (1 bit).
  - i_halt=1 at an edge sets sticky o_halted=1 after that edge.
  - While o_halted=1, o_pc is frozen regardless of stall, jump or branch.
  - Only reset clears o_halted (o_halted reset value 0).
  - i_halt has priority just below reset. On the edge where i_halt rises, o_pc does not advance.
- Not defined: neither port exists and the behaviour is exactly as above.

Test Plan:
- Hold i_rst=0 for 1 edge, then i_rst=1 with all controls 0 for 3 edges -> o_pc sequence 0,1,2,3; o_pc_plus_step=4 at the end.
- From o_pc=5: i_stall=1 for 2 edges -> o_pc stays 5. Then i_stall=1 with i_jump_en=1 and i_jump_addr=100 -> still 5. Release stall -> increments to 6.
- i_jump_en=1, i_jump_addr=36'h0_0000_1000, with i_branch_en=1 at the same edge -> o_pc=36'h1000. Next edge with no controls -> 36'h1001.
- From o_pc=10: i_branch_off = -4 (36'hF_FFFF_FFFC) -> o_pc=6. From o_pc=2 with offset -4 -> o_pc=36'hF_FFFF_FFFE.
- Jump to 36'hF_FFFF_FFFF, then one free-running edge -> o_pc=0 (wrap). Pull i_rst=0 at o_pc=7 while i_jump_en=1 -> o_pc=0.
- PC_HALT_EN defined: count to 3, pulse i_halt -> o_halted=1 and o_pc stays 3 for 5 edges despite i_jump_en. i_rst=0 -> o_pc=0 and o_halted=0.
